// File: rtl/store_buffer_mod_if.sv
//------------------------------------------------------------------------------
// store_buffer_mod_if
//
// Purpose:
//   Groups the store-buffer signals that run between the MEM stage, the store
//   buffer and data_memory_mod. Clock and reset are separate scalar ports on
//   the modules that use this interface.
//
// Parameters:
//   N      byte-address width; must match data_memory_mod
//   DEPTH  number of store-buffer entries (power of two, >= 2)
//
// Signals (direction given for the store buffer, i.e. the slave modport):
//   st_valid_i       in   store request from the MEM stage
//   st_addr_i        in   store byte address, word is big-endian at addr..addr+3
//   st_data_i        in   store data, bits [0:7] land at st_addr_i
//   st_ready_o       out  buffer can take a store this cycle
//   ld_valid_i       in   load request from the MEM stage
//   ld_addr_i        in   load byte address
//   ld_data_o        out  load result, forwarded or from memory
//   ld_stall_o       out  load cannot complete this cycle
//   mem_addr_o       out  shared data-memory address
//   mem_write_data_o out  data-memory write data
//   mem_write_en_o   out  data-memory write enable
//   mem_read_data_i  in   data-memory read data
//   count_o          out  current number of buffered stores
//
// Modports:
//   master  MEM stage plus data memory (drives the *_i signals)
//   slave   the store buffer itself
//------------------------------------------------------------------------------
`timescale 1ns/1ps
interface store_buffer_mod_if #(
  parameter int N     = 10,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          st_valid_i;
  logic [0:N-1]  st_addr_i;
  logic [0:31]   st_data_i;
  logic          st_ready_o;

  logic          ld_valid_i;
  logic [0:N-1]  ld_addr_i;
  logic [0:31]   ld_data_o;
  logic          ld_stall_o;

  logic [0:N-1]  mem_addr_o;
  logic [0:31]   mem_write_data_o;
  logic          mem_write_en_o;
  logic [0:31]   mem_read_data_i;

  logic [CW-1:0] count_o;

  modport master (
    output st_valid_i, st_addr_i, st_data_i,
    output ld_valid_i, ld_addr_i,
    output mem_read_data_i,
    input  st_ready_o, ld_data_o, ld_stall_o,
    input  mem_addr_o, mem_write_data_o, mem_write_en_o,
    input  count_o
  );

  modport slave (
    input  st_valid_i, st_addr_i, st_data_i,
    input  ld_valid_i, ld_addr_i,
    input  mem_read_data_i,
    output st_ready_o, ld_data_o, ld_stall_o,
    output mem_addr_o, mem_write_data_o, mem_write_en_o,
    output count_o
  );
endinterface

// File: rtl/store_buffer_mod.sv
//------------------------------------------------------------------------------
// store_buffer_mod
//
// Purpose:
//   Store buffer in the MEM stage, directly upstream of the single-port
//   data_memory_mod. Committed word stores are queued in a circular FIFO and
//   drained into memory, oldest first, whenever a load is not using the port.
//   Loads are checked against every buffered store: an exact match on the
//   youngest overlapping store is forwarded, a partial overlap stalls until
//   that store has drained, and a load that overlaps nothing reads memory.
//
// Parameters:
//   N      byte-address width (matches data_memory_mod)
//   DEPTH  number of store entries, power of two, >= 2
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst_n  asynchronous active-low reset; discards every buffered store
//   bus    store_buffer_mod_if.slave (store/load requests, memory port,
//          occupancy); see the interface file for the signal list
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module store_buffer_mod #(
  parameter int N     = 10,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  store_buffer_mod_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Load classification against the buffered stores.
  typedef enum logic [1:0] {
    LD_MEM     = 2'd0,   // no overlap: memory serves the load
    LD_FWD     = 2'd1,   // youngest overlapping store matches exactly
    LD_PARTIAL = 2'd2,   // youngest overlapping store overlaps partially
    LD_FULL    = 2'd3    // buffer full: load waits so the head can drain
  } ld_class_e;

  //--------------------------------------------------------------------------
  // State
  //--------------------------------------------------------------------------
  logic [0:N-1]  r_addr [DEPTH];
  logic [0:31]   r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  //--------------------------------------------------------------------------
  // Combinational signals
  //--------------------------------------------------------------------------
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_load_uses_port;
  logic [DEPTH-1:0] w_slot_overlap;
  logic [DEPTH-1:0] w_slot_exact;
  logic             w_hit;
  logic [PW-1:0]    w_hit_slot;
  logic             w_hit_exact;
  ld_class_e        w_class;

  assign w_full = (r_count == CW'(DEPTH));

  //--------------------------------------------------------------------------
  // Per-slot address compare.
  // A slot is live when its distance from the head is below the count. Two
  // word accesses overlap when their start addresses are within 3 bytes of
  // each other in either direction, measured modulo 2^N so that words
  // wrapping past the top of memory are caught just as the memory wraps.
  //--------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PW-1:0] w_age;
      logic          w_valid;
      logic [N-1:0]  w_st_minus_ld;
      logic [N-1:0]  w_ld_minus_st;

      assign w_age         = PW'(gi) - r_head;
      assign w_valid       = (CW'(w_age) < r_count);
      assign w_st_minus_ld = r_addr[gi] - bus.ld_addr_i;
      assign w_ld_minus_st = bus.ld_addr_i - r_addr[gi];

      assign w_slot_overlap[gi] = w_valid &&
                                  ((w_st_minus_ld <= N'(3)) ||
                                   (w_ld_minus_st <= N'(3)));
      assign w_slot_exact[gi]   = (r_addr[gi] == bus.ld_addr_i);
    end
  endgenerate

  //--------------------------------------------------------------------------
  // Youngest overlapping entry: walk from oldest to youngest so the last hit
  // found is the most recent store to that region.
  //--------------------------------------------------------------------------
  always_comb begin
    w_hit      = 1'b0;
    w_hit_slot = r_head;
    for (int a = 0; a < DEPTH; a++) begin
      if (w_slot_overlap[r_head + PW'(a)]) begin
        w_hit      = 1'b1;
        w_hit_slot = r_head + PW'(a);
      end
    end
  end

  assign w_hit_exact = w_slot_exact[w_hit_slot];

  // A full buffer stalls every load so that the drain always gets the port;
  // otherwise a stream of loads could keep the buffer full forever.
  always_comb begin
    w_class = LD_MEM;
    if (w_full) begin
      w_class = LD_FULL;
    end else if (w_hit) begin
      w_class = w_hit_exact ? LD_FWD : LD_PARTIAL;
    end
  end

  //--------------------------------------------------------------------------
  // Port arbitration and outputs.
  // Nothing here depends on the st_* inputs: a store is only seen after it
  // has been written into the FIFO.
  //--------------------------------------------------------------------------
  assign w_load_uses_port = bus.ld_valid_i && (w_class == LD_MEM);
  assign w_pop            = (r_count != '0) && !w_load_uses_port;
  assign w_push           = bus.st_valid_i && !w_full;

  assign bus.st_ready_o       = !w_full;
  assign bus.count_o          = r_count;
  assign bus.mem_write_en_o   = w_pop;
  assign bus.mem_addr_o       = w_load_uses_port ? bus.ld_addr_i : r_addr[r_head];
  assign bus.mem_write_data_o = r_data[r_head];

  assign bus.ld_stall_o = bus.ld_valid_i &&
                          ((w_class == LD_FULL) || (w_class == LD_PARTIAL));

  assign bus.ld_data_o  = (bus.ld_valid_i && (w_class == LD_FWD)) ?
                          r_data[w_hit_slot] : bus.mem_read_data_i;

  //--------------------------------------------------------------------------
  // Pointers and occupancy. Reset only clears these; stale entry contents
  // are harmless because nothing outside head..head+count-1 is ever used.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Entry storage. A push into the slot being drained on the same edge
  // cannot happen: a push needs a free slot, so tail never equals a live head.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= bus.st_addr_i;
      r_data[r_tail] <= bus.st_data_i;
    end
  end

endmodule

// File: tb/tb_store_buffer_mod.sv
`timescale 1ns/1ps
module tb_store_buffer_mod;

  localparam int N     = 10;
  localparam int DEPTH = 4;
  localparam int MSZ   = 1 << N;

  logic clk       = 1'b0;
  logic rst_n     = 1'b1;
  logic mem_clear = 1'b1;

  always #5 clk = ~clk;

  store_buffer_mod_if #(.N(N), .DEPTH(DEPTH)) bus ();

  store_buffer_mod #(.N(N), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  //--------------------------------------------------------------------------
  // Data memory seen by the DUT: asynchronous read, write on rising edge.
  //--------------------------------------------------------------------------
  logic [7:0]   tb_mem [MSZ];
  logic [N-1:0] ma;
  logic [31:0]  wd;

  assign ma = bus.mem_addr_o;
  assign wd = bus.mem_write_data_o;
  assign bus.mem_read_data_i = {tb_mem[ma], tb_mem[ma + N'(1)],
                                tb_mem[ma + N'(2)], tb_mem[ma + N'(3)]};

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < MSZ; i++) tb_mem[i] <= init_byte(i);
    end else if (bus.mem_write_en_o) begin
      tb_mem[ma]          <= wd[31:24];
      tb_mem[ma + N'(1)]  <= wd[23:16];
      tb_mem[ma + N'(2)]  <= wd[15:8];
      tb_mem[ma + N'(3)]  <= wd[7:0];
    end
  end

  //--------------------------------------------------------------------------
  // Reference model: program-order list of pending stores and a byte memory.
  //--------------------------------------------------------------------------
  typedef struct {
    logic [N-1:0] addr;
    logic [31:0]  data;
  } st_t;

  typedef struct {
    logic         ld_valid;
    logic         stall;
    logic [31:0]  ld_data;
    logic         wen;
    logic [N-1:0] waddr;
    logic [31:0]  wdata;
    logic         st_ready;
    int           count;
  } exp_t;

  st_t        pend[$];
  exp_t       exp_q[$];
  logic [7:0] ref_mem [MSZ];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [N-1:0] a);
    return {ref_mem[a], ref_mem[a + N'(1)], ref_mem[a + N'(2)], ref_mem[a + N'(3)]};
  endfunction

  function automatic bit overlaps(input logic [N-1:0] st_a, input logic [N-1:0] ld_a);
    int d;
    d = (int'(st_a) - int'(ld_a) + MSZ) % MSZ;
    return (d <= 3) || (d >= MSZ - 3);
  endfunction

  // One clock cycle: drive inputs, predict the DUT response, then advance the
  // model across the rising edge. Called and returns at posedge + 1.
  task automatic cycle(input logic sv, input logic [N-1:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [N-1:0] la, output logic accepted);
    exp_t e;
    int   hit;
    logic use_port;
    bus.st_valid_i = sv;
    bus.st_addr_i  = sa;
    bus.st_data_i  = sd;
    bus.ld_valid_i = lv;
    bus.ld_addr_i  = la;

    hit = -1;
    for (int i = 0; i < pend.size(); i++)
      if (overlaps(pend[i].addr, la)) hit = i;

    e.ld_valid = lv;
    e.stall    = 1'b0;
    e.ld_data  = ref_word(la);
    use_port   = 1'b0;
    if (lv) begin
      if (pend.size() == DEPTH) e.stall = 1'b1;
      else if (hit >= 0) begin
        if (pend[hit].addr == la) e.ld_data = pend[hit].data;
        else e.stall = 1'b1;
      end else use_port = 1'b1;
    end
    e.wen   = (pend.size() > 0) && !use_port;
    e.waddr = '0;
    e.wdata = '0;
    if (e.wen) begin
      e.waddr = pend[0].addr;
      e.wdata = pend[0].data;
    end
    e.st_ready = (pend.size() < DEPTH);
    e.count    = pend.size();
    accepted   = sv && e.st_ready;
    exp_q.push_back(e);

    @(posedge clk);
    if (e.wen) begin
      ref_mem[e.waddr]          = e.wdata[31:24];
      ref_mem[e.waddr + N'(1)]  = e.wdata[23:16];
      ref_mem[e.waddr + N'(2)]  = e.wdata[15:8];
      ref_mem[e.waddr + N'(3)]  = e.wdata[7:0];
      void'(pend.pop_front());
    end
    if (accepted) pend.push_back('{addr: sa, data: sd});
    #1;
  endtask

  task automatic idle(input int n, input logic lv, input logic [N-1:0] la);
    logic acc;
    for (int k = 0; k < n; k++) cycle(1'b0, '0, '0, lv, la, acc);
  endtask

  // Upstream behaviour: hold a store until the buffer takes it.
  task automatic push_hold(input logic [N-1:0] sa, input logic [31:0] sd,
                           input logic lv, input logic [N-1:0] la);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 8 && !acc; k++) cycle(1'b1, sa, sd, lv, la, acc);
    chk("push_accepted", 32'(acc), 32'd1);
  endtask

  //--------------------------------------------------------------------------
  // Monitor: pops one expectation per cycle and compares the DUT outputs.
  //--------------------------------------------------------------------------
  exp_t me;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      chk("count", 32'(bus.count_o), 32'(me.count));
      chk("st_ready", 32'(bus.st_ready_o), 32'(me.st_ready));
      chk("mem_write_en", 32'(bus.mem_write_en_o), 32'(me.wen));
      if (me.wen && bus.mem_write_en_o) begin
        chk("mem_addr", 32'(ma), 32'(me.waddr));
        chk("mem_write_data", wd, me.wdata);
      end
      if (me.ld_valid) chk("ld_stall", 32'(bus.ld_stall_o), 32'(me.stall));
      if (me.ld_valid && !me.stall) chk("ld_data", bus.ld_data_o, me.ld_data);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  //--------------------------------------------------------------------------
  // Stimulus
  //--------------------------------------------------------------------------
  logic         acc_r;
  logic [N-1:0] ra, rl;
  int           nmis;

  initial begin
    for (int i = 0; i < MSZ; i++) ref_mem[i] = init_byte(i);
    bus.st_valid_i = 1'b0;
    bus.st_addr_i  = '0;
    bus.st_data_i  = '0;
    bus.ld_valid_i = 1'b0;
    bus.ld_addr_i  = '0;

    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 mem_clear = 1'b0;
    bus.ld_valid_i = 1'b1;
    bus.ld_addr_i  = N'(10'h123);
    #1;
    chk("reset_count", 32'(bus.count_o), 32'd0);
    chk("reset_st_ready", 32'(bus.st_ready_o), 32'd1);
    chk("reset_wen", 32'(bus.mem_write_en_o), 32'd0);
    chk("reset_stall", 32'(bus.ld_stall_o), 32'd0);
    chk("reset_ld_data", bus.ld_data_o, ref_word(N'(10'h123)));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single store drains on the next cycle
    cycle(1'b1, N'(10'h010), 32'hDEADBEEF, 1'b0, '0, acc_r);
    idle(2, 1'b0, '0);
    chk("t1_mem_word", {tb_mem[16], tb_mem[17], tb_mem[18], tb_mem[19]}, 32'hDEADBEEF);
    chk("t1_count", 32'(bus.count_o), 32'd0);

    // 2: two stores to the same word, load forwards the younger one
    cycle(1'b1, N'(10'h020), 32'h11111111, 1'b1, N'(10'h020), acc_r);
    cycle(1'b1, N'(10'h020), 32'h22222222, 1'b1, N'(10'h020), acc_r);
    idle(3, 1'b1, N'(10'h020));
    idle(2, 1'b0, '0);
    chk("t2_mem_word", {tb_mem[32], tb_mem[33], tb_mem[34], tb_mem[35]}, 32'h22222222);

    // 3: partial overlap stalls for one drain, then memory serves the load
    cycle(1'b1, N'(10'h040), 32'hCAFEF00D, 1'b0, '0, acc_r);
    idle(2, 1'b1, N'(10'h042));

    // 4: fill the buffer under a continuous non-overlapping load stream
    for (int i = 0; i < 5; i++)
      push_hold(N'(10'h100 + 4 * i), 32'hA0000000 + 32'(i), 1'b1, N'(10'h200));
    idle(3, 1'b1, N'(10'h200));
    idle(6, 1'b0, '0);

    // 5: overlap across the address wrap
    cycle(1'b1, N'(10'h3FE), 32'h0BADBEEF, 1'b0, '0, acc_r);
    cycle(1'b0, '0, '0, 1'b1, N'(10'h3FA), acc_r);
    idle(2, 1'b1, N'(10'h000));

    // 6: reset with three stores pending
    for (int i = 0; i < 3; i++)
      push_hold(N'(10'h300 + 4 * i), 32'h55AA0000 + 32'(i), 1'b1, N'(10'h200));
    chk("t6_pre_count", 32'(bus.count_o), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_count", 32'(bus.count_o), 32'd0);
    chk("t6_rst_wen", 32'(bus.mem_write_en_o), 32'd0);
    chk("t6_rst_st_ready", 32'(bus.st_ready_o), 32'd1);
    chk("t6_rst_stall", 32'(bus.ld_stall_o), 32'd0);
    pend.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4, 1'b0, '0);

    // Random traffic near the wrap point with frequent exact matches
    for (int c = 0; c < 400; c++) begin
      ra = N'((MSZ - 8 + int'($urandom_range(0, 15))) % MSZ);
      if ($urandom_range(0, 1) == 1 && pend.size() > 0)
        rl = pend[$urandom_range(0, pend.size() - 1)].addr;
      else
        rl = N'((MSZ - 8 + int'($urandom_range(0, 15))) % MSZ);
      cycle(1'($urandom_range(0, 1)), ra, $urandom, 1'($urandom_range(0, 3) != 0), rl, acc_r);
    end
    idle(DEPTH + 2, 1'b0, '0);

    nmis = 0;
    for (int i = 0; i < MSZ; i++) if (tb_mem[i] !== ref_mem[i]) nmis++;
    chk("final_mem_mismatches", 32'(nmis), 32'd0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
